// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the two-port data-memory arbiter.
package dmem_arb_pkg;

  localparam int XLEN   = 32;
  localparam int MODE_W = 3;

  // Registered owner of the dmem port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

endpackage

// File: rtl/dmem_arb_pick.sv
// Two-way arbitration pick for the dmem arbiter.
// Tie policy: with DMEM_ARB_RR_EN defined the port that was not served last
// wins; otherwise port 0 always wins a tie.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic   req0_i,
  input  logic   req1_i,
  input  logic   last_served_i,
  output owner_e owner_o
);

  owner_e tie_owner;

`ifdef DMEM_ARB_RR_EN
  assign tie_owner = last_served_i ? OWN0 : OWN1;
`else
  logic unused_last_served;
  assign unused_last_served = last_served_i;
  assign tie_owner          = OWN0;
`endif

  // Select the next owner from the requests present this cycle.
  always_comb begin
    // NOTE: owner_o is given a default first so every path assigns it and no latch is inferred.
    owner_o = IDLE;
    if (req0_i && req1_i) begin
      owner_o = tie_owner;
    end else if (req0_i) begin
      owner_o = OWN0;
    end else if (req1_i) begin
      owner_o = OWN1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one dmem port between the load/store port (0) and a secondary
// master (1). Grants follow a registered owner, locked bursts are bounded
// by MAX_BURST, and read data returns registered one cycle after the grant.
// Optional macro DMEM_ARB_RR_EN selects round-robin ties (default: port 0
// has fixed priority).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [XLEN-1:0]   addr0,
  input  logic [XLEN-1:0]   addr1,
  input  logic [XLEN-1:0]   wd0,
  input  logic [XLEN-1:0]   wd1,
  input  logic [MODE_W-1:0] mode0,
  input  logic [MODE_W-1:0] mode1,
  input  logic              lock0,
  input  logic              lock1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [XLEN-1:0]   rdata0,
  output logic [XLEN-1:0]   rdata1,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_a,
  output logic [XLEN-1:0]   mem_wd,
  output logic [MODE_W-1:0] mem_mode,
  input  logic [XLEN-1:0]   mem_rd
);

  localparam int               CNT_W     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  // Highest burst count at which a locked owner may still keep the port.
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  owner_e            owner_q, owner_d, pick_owner;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              last_served_q, last_served_d;
  logic              rvalid0_q, rvalid1_q;
  logic [XLEN-1:0]   rdata0_q, rdata1_q;

  // A grant is also the transfer: the owner is requesting this cycle.
  assign gnt0 = (owner_q == OWN0) && req0;
  assign gnt1 = (owner_q == OWN1) && req1;

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;

  // Drive the dmem port from the granted requester, otherwise all zero.
  always_comb begin
    mem_we   = 1'b0;
    mem_a    = '0;
    mem_wd   = '0;
    mem_mode = '0;
    if (gnt0) begin
      mem_we   = we0;
      mem_a    = addr0;
      mem_wd   = wd0;
      mem_mode = mode0;
    end else if (gnt1) begin
      mem_we   = we1;
      mem_a    = addr1;
      mem_wd   = wd1;
      mem_mode = mode1;
    end
  end

  // The tie policy sees this cycle's transfer, so alternation has no repeats.
  always_comb begin
    last_served_d = last_served_q;
    if (gnt0) begin
      last_served_d = 1'b0;
    end else if (gnt1) begin
      last_served_d = 1'b1;
    end
  end

  dmem_arb_pick u_pick (
    .req0_i        (req0),
    .req1_i        (req1),
    .last_served_i (last_served_d),
    .owner_o       (pick_owner)
  );

  // Next owner: extend a locked burst while under the limit, else re-arbitrate.
  always_comb begin
    owner_d     = pick_owner;
    burst_cnt_d = '0;
    if (gnt0 && lock0 && (burst_cnt_q < LAST_BEAT)) begin
      owner_d     = OWN0;
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end else if (gnt1 && lock1 && (burst_cnt_q < LAST_BEAT)) begin
      owner_d     = OWN1;
      burst_cnt_d = burst_cnt_q + CNT_W'(1);
    end
  end

  // Owner, burst count and last-served registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      owner_q       <= IDLE;
      burst_cnt_q   <= '0;
      last_served_q <= 1'b1;
    end else begin
      owner_q       <= owner_d;
      burst_cnt_q   <= burst_cnt_d;
      last_served_q <= last_served_d;
    end
  end

  // Capture read data for the port whose read was accepted this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 && !we0;
      rvalid1_q <= gnt1 && !we1;
      if (gnt0 && !we0) begin
        rdata0_q <= mem_rd;
      end
      if (gnt1 && !we1) begin
        rdata1_q <= mem_rd;
      end
    end
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single data memory (dmem) between the processor's load/store port (port 0) and a secondary master such as a loader or DMA engine (port 1). It serialises accesses onto the one dmem port, passes the access size/sign mode through, registers read data back to the winning requester, and supports bounded locked bursts. It sits between the core/secondary master and dmem, replacing the direct core-to-dmem connection.

## Interface
- MAX_BURST, 8: maximum consecutive locked transfers one port may hold the memory; ≥1.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request from port k; held until accepted.
- we0 / we1  in  1  write enable of port k's access.
- addr0 / addr1  in  32  byte address.
- wd0 / wd1  in  32  write data.
- mode0 / mode1  in  3  funct3-style size/sign mode, passed unchanged to memory.
- lock0 / lock1  in  1  request to keep ownership for the next transfer.
- gnt0 / gnt1  out  1  transfer accepted this cycle.
- rvalid0 / rvalid1  out  1  rdata valid, one cycle after an accepted read.
- rdata0 / rdata1  out  32  registered read data.
- mem_we  out  1  dmem write enable.
- mem_a  out  32  dmem address.
- mem_wd  out  32  dmem write data.
- mem_mode  out  3  dmem mode.
- mem_rd  in  32  dmem combinational read data.

## Operation
- Registered owner state: IDLE, OWN0, OWN1. gnt_k = (owner==OWNk) & req_k. A transfer occurs in every cycle where req_k & gnt_k.
- Memory port driven from owner's signals when gnt_k; otherwise mem_we=0, mem_a=0, mem_wd=0, mem_mode=0.
- Next owner, computed every cycle:
  - Stay: current owner transferred, lock_k=1, burst_cnt < MAX_BURST-1 → same owner, burst_cnt+1.
  - Otherwise arbitrate among req0/req1 (requests this cycle): none → IDLE; one → that port; both → policy (see Configuration). burst_cnt ← 0.
- Owner with req_k low loses ownership at next edge (re-arbitration, no transfer).
- Requester must hold we/addr/wd/mode/lock stable while req high and gnt low.
- On an accepted read (we_k=0): rdata_k ← mem_rd at that edge, rvalid_k=1 next cycle only. Writes produce no rvalid. rdata_k holds last value otherwise.
- last_served register updated to k on every transfer by port k.

## Timing
- Request-to-grant: ≥1 cycle (owner registered); from IDLE, req at cycle t → gnt at t+1.
- Back-to-back: an owner keeping req high transfers every cycle while it remains owner; no idle bubble on handover between ports.
- Read latency: data on rdata_k with rvalid_k one cycle after gnt.
- Write committed by dmem at the edge ending the gnt cycle.
- Reset (asynchronous, any time incl. mid-burst): owner=IDLE, burst_cnt=0, last_served=1, rvalid0/1=0, rdata0/1=0, gnt=0, all mem_* outputs 0. In-flight read data is discarded.
- MAX_BURST=1: lock has no effect; ownership re-arbitrated every transfer.
- Simultaneous lock expiry and competing request: expiring owner competes normally under policy.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin; on tie, grant the port ≠ last_served.
- Not defined: fixed priority, port 0 wins every tie; port 1 can starve while port 0 requests continuously. MAX_BURST limit still applies to both.

## Structure
- Package dmem_arb_pkg: owner_e enum (IDLE, OWN0, OWN1), MODE_W=3, XLEN=32.
- Sub-module dmem_arb_pick: combinational two-way pick from req0, req1, last_served and policy macro; returns next owner.

## Test plan
- Reset release, req0=1 read addr 0x10 (mem holds 0xDEADBEEF) → gnt0 at cycle 1, rvalid0=1, rdata0=0xDEADBEEF at cycle 2.
- req0 and req1 asserted together from IDLE, held, no lock, RR enabled → grants alternate 0,1,0,1; fixed priority → gnt0 every cycle, gnt1 never.
- Port 1 lock1=1, req1 held, MAX_BURST=4, req0 pending → exactly 4 consecutive gnt1 then gnt0.
- Port 0 write 0x12345678 to 0x20, mode=010, then port 1 read 0x20 → mem_we=1 only in gnt0 cycle; rdata1=0x12345678.
- Assert reset low mid-burst with a read granted → all outputs 0 immediately, rvalid never asserts for that read; after release, first tie goes to port 0.
- Owner drops req while owner → no transfer, mem_we=0, owner re-arbitrated next edge.
